rv_iopmp_err_arbiter: RTL

RV_IOPMP_ERR_ARBITER -- requirements
Module: rv_iopmp_err_arbiter

---
 rtl/rv_iopmp_err_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rv_iopmp_err_arbiter.sv
// rv_iopmp_err_arbiter
// Collects error reports from NUM_REQ IOPMP matching instances, picks one by
// round-robin, writes it into the error-record registers and raises ip. While
// a record is pending (LOCKED), further reports are either dropped and counted
// or back-pressured, depending on drop_en_i.
module rv_iopmp_err_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int SID_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       err_valid_i,
    output logic [NUM_REQ-1:0]       err_ready_o,
    input  logic [NUM_REQ*2-1:0]     err_ttype_i,
    input  logic [NUM_REQ*3-1:0]     err_etype_i,
    input  logic [NUM_REQ*SID_W-1:0] err_sid_i,
    input  logic [NUM_REQ*16-1:0]    err_eid_i,
    input  logic [NUM_REQ*64-1:0]    err_addr_i,
    input  logic                     drop_en_i,
    input  logic                     ie_i,
    input  logic                     clr_ip_i,
    input  logic                     clr_cnt_i,
    output logic                     rec_we_o,
    output logic [1:0]               rec_ttype_o,
    output logic [2:0]               rec_etype_o,
    output logic [SID_W-1:0]         rec_sid_o,
    output logic [15:0]              rec_eid_o,
    output logic [31:0]              rec_addr_o,
    output logic [31:0]              rec_addrh_o,
    output logic                     ip_o,
    output logic                     irq_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [PTR_W-1:0]   cand_s, win_idx_s;
    logic               win_found_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_fire_s;
    logic               drop_s;
    logic               ip_r, ip_s;
    logic [15:0]        drop_cnt_r;

    logic [1:0]         pl_ttype_r;
    logic [2:0]         pl_etype_r;
    logic [SID_W-1:0]   pl_sid_r;
    logic [15:0]        pl_eid_r;
    logic [63:0]        pl_addr_r;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {PTR_W{1'b0}};
        cand_s      = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_REQ);
            if (!win_found_s && err_valid_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        grant_s = NUM_REQ'(1'b1) << win_idx_s;
    end

    // Next state, handshakes, write strobe and ip/rr_ptr updates.
    always_comb begin
        state_s      = state_r;
        rr_ptr_s     = rr_ptr_r;
        ip_s         = ip_r;
        err_ready_o  = {NUM_REQ{1'b0}};
        rec_we_o     = 1'b0;
        grant_fire_s = 1'b0;
        drop_s       = 1'b0;
        if (rst_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        err_ready_o  = grant_s;
                        grant_fire_s = 1'b1;
                        rr_ptr_s     = (win_idx_s == PTR_W'(NUM_REQ - 1)) ?
                                       {PTR_W{1'b0}} : win_idx_s + PTR_W'(1);
                        state_s      = ST_COMMIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    rec_we_o = 1'b1;
                    ip_s     = 1'b1;
                    state_s  = ST_LOCKED;
                end
                ST_LOCKED: begin
                    // Drop rules still apply in the cycle that clears ip.
                    if (drop_en_i) begin
                        err_ready_o = err_valid_i;
                        drop_s      = |err_valid_i;
                    end else begin
                        err_ready_o = {NUM_REQ{1'b0}};
                    end
                    if (clr_ip_i) begin
                        ip_s    = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, round-robin pointer and pending flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= {PTR_W{1'b0}};
            ip_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            ip_r     <= ip_s;
        end
    end

    // Latch the winner's payload on grant; it feeds the record outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pl_ttype_r <= 2'd0;
            pl_etype_r <= 3'd0;
            pl_sid_r   <= {SID_W{1'b0}};
            pl_eid_r   <= 16'd0;
            pl_addr_r  <= 64'd0;
        end else if (grant_fire_s) begin
            pl_ttype_r <= err_ttype_i[int'(win_idx_s)*2 +: 2];
            pl_etype_r <= err_etype_i[int'(win_idx_s)*3 +: 3];
            pl_sid_r   <= err_sid_i[int'(win_idx_s)*SID_W +: SID_W];
            pl_eid_r   <= err_eid_i[int'(win_idx_s)*16 +: 16];
            pl_addr_r  <= err_addr_i[int'(win_idx_s)*64 +: 64];
        end else begin
            pl_ttype_r <= pl_ttype_r;
            pl_etype_r <= pl_etype_r;
            pl_sid_r   <= pl_sid_r;
            pl_eid_r   <= pl_eid_r;
            pl_addr_r  <= pl_addr_r;
        end
    end

    // Saturating drop counter; a clear wins over a coincident drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'd0;
        end else if (clr_cnt_i) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign rec_ttype_o = pl_ttype_r;
    assign rec_etype_o = pl_etype_r;
    assign rec_sid_o   = pl_sid_r;
    assign rec_eid_o   = pl_eid_r;
    assign rec_addr_o  = pl_addr_r[31:0];
    assign rec_addrh_o = pl_addr_r[63:32];
    assign ip_o        = ip_r;
    assign irq_o       = ip_r & ie_i;
    assign drop_cnt_o  = drop_cnt_r;

endmodule
